// File: rtl/pxd_quad_train_pkg.sv
// Shared types and helpers for the per-bit sample-phase selector and its training FSM.
package pxd_quad_train_pkg;

  localparam int QUAD_W = 2;
  localparam int NPH    = 1 << QUAD_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_DECIDE = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } train_state_e;

  // Ties resolve to the lowest index: only a strictly larger count moves the pick.
  function automatic logic [QUAD_W-1:0] max_idx4(input logic [31:0] c0, input logic [31:0] c1,
                                                 input logic [31:0] c2, input logic [31:0] c3);
    logic [QUAD_W-1:0] k;
    logic [31:0]       m;
    k = 2'd0;
    m = c0;
    if (c1 > m) begin k = 2'd1; m = c1; end
    if (c2 > m) begin k = 2'd2; m = c2; end
    if (c3 > m) begin k = 2'd3; end
    return k;
  endfunction

endpackage

// File: rtl/pxd_quad_train_edge_hist.sv
// Edge histogram for the bit under training: four boundary counters plus the window counter.
module pxd_edge_hist
  import pxd_quad_train_pkg::*;
#(
  parameter int WIN_LOG = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             acc_i,
  input  logic [NPH-1:0]   edges_i,
  output logic [WIN_LOG:0] cnt0_o,
  output logic [WIN_LOG:0] cnt1_o,
  output logic [WIN_LOG:0] cnt2_o,
  output logic [WIN_LOG:0] cnt3_o,
  output logic             win_end_o
);

  logic [WIN_LOG:0]   cnt_q [NPH];
  logic [WIN_LOG-1:0] win_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int k = 0; k < NPH; k++) cnt_q[k] <= '0;
      win_q <= '0;
    end else if (acc_i) begin
      for (int k = 0; k < NPH; k++) cnt_q[k] <= cnt_q[k] + {{WIN_LOG{1'b0}}, edges_i[k]};
      win_q <= win_q + 1'b1;
    end
  end

  // High on the last accumulate cycle of the window; counts are final one cycle later.
  assign win_end_o = acc_i & (&win_q);
  assign cnt0_o    = cnt_q[0];
  assign cnt1_o    = cnt_q[1];
  assign cnt2_o    = cnt_q[2];
  assign cnt3_o    = cnt_q[3];

endmodule

// File: rtl/pxd_quad_train.sv
// Per-bit quadrant sample selection with automatic edge-based phase training.
// Optional macro PXD_TRAIN_STATS_EN adds the train_stats capture output.
module pxd_quad_train
  import pxd_quad_train_pkg::*;
#(
  parameter int          WIDTH     = 12,
  parameter int          WIN_LOG   = 10,
  parameter logic [1:0]  QUAD_INIT = 2'd0
) (
  input  logic                   mclk,
  input  logic                   mrst,
  input  logic [4*WIDTH-1:0]     dout_quads,
  output logic [WIDTH-1:0]       pxd_in,
  input  logic [2*WIDTH-1:0]     quad_manual,
  input  logic                   quad_set,
  input  logic                   train_start,
  output logic                   train_busy,
  output logic                   train_done,
  output logic [WIDTH-1:0]       train_err,
  output logic [2*WIDTH-1:0]     quad_cur,
`ifdef PXD_TRAIN_STATS_EN
  output logic [4*(WIN_LOG+1)+$clog2(WIDTH)-1:0] train_stats,
`endif
  output train_state_e           fsm_state
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  train_state_e          state_q;
  logic [BW-1:0]         bit_q;
  logic [2*WIDTH-1:0]    quad_cur_q;
  logic [WIDTH-1:0]      train_err_q;
  logic                  busy_q;
  logic                  done_q;
  logic [WIDTH-1:0]      pxd_q;
  logic [WIDTH-1:0]      pxd_d;
  logic [WIDTH-1:0]      s3_prev_q;
  logic [WIDTH-1:0]      s3_now;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic [NPH-1:0]    nib;
    logic [QUAD_W-1:0] q;
    assign nib       = dout_quads[4*g +: 4];
    assign q         = quad_cur_q[2*g +: 2];
    assign pxd_d[g]  = nib[q];
    assign s3_now[g] = nib[3];
  end

  // Samples of the bit currently being trained, plus its last-cycle s3.
  logic [NPH-1:0] cur_nib;
  logic           cur_s3p;
  logic [NPH-1:0] edges;

  always_comb begin
    cur_nib = '0;
    cur_s3p = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bit_q == BW'(i)) begin
        cur_nib = dout_quads[4*i +: 4];
        cur_s3p = s3_prev_q[i];
      end
    end
    edges = {cur_s3p ^ cur_nib[0], cur_nib[2] ^ cur_nib[3],
             cur_nib[1] ^ cur_nib[2], cur_nib[0] ^ cur_nib[1]};
  end

  logic [WIN_LOG:0] cnt0, cnt1, cnt2, cnt3;
  logic             win_end;

  pxd_edge_hist #(.WIN_LOG(WIN_LOG)) u_hist (
    .clk_i     (mclk),
    .rst_i     (mrst),
    .clr_i     (state_q == ST_CLEAR),
    .acc_i     (state_q == ST_ACCUM),
    .edges_i   (edges),
    .cnt0_o    (cnt0),
    .cnt1_o    (cnt1),
    .cnt2_o    (cnt2),
    .cnt3_o    (cnt3),
    .win_end_o (win_end)
  );

  logic [QUAD_W-1:0] best_k;
  logic              any_edge;

  assign best_k   = max_idx4(32'(cnt0), 32'(cnt1), 32'(cnt2), 32'(cnt3));
  assign any_edge = |{cnt0, cnt1, cnt2, cnt3};

  always_ff @(posedge mclk) begin
    if (mrst) begin
      state_q     <= ST_IDLE;
      bit_q       <= '0;
      quad_cur_q  <= {WIDTH{QUAD_INIT}};
      train_err_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pxd_q       <= '0;
      s3_prev_q   <= '0;
    end else begin
      pxd_q     <= pxd_d;
      s3_prev_q <= s3_now;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A simultaneous quad_set still lands; training then overrides bit by bit.
          if (quad_set) quad_cur_q <= quad_manual;
          if (train_start) begin
            state_q <= ST_CLEAR;
            bit_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: state_q <= ST_ACCUM;
        ST_ACCUM: if (win_end) state_q <= ST_DECIDE;
        ST_DECIDE: begin
          // Sample half a period away from the busiest boundary.
          for (int i = 0; i < WIDTH; i++) begin
            if (bit_q == BW'(i)) begin
              if (any_edge) begin
                quad_cur_q[2*i +: 2] <= best_k + 2'd2;
                train_err_q[i]       <= 1'b0;
              end else begin
                train_err_q[i]       <= 1'b1;
              end
            end
          end
          state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (bit_q == LAST_BIT) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            bit_q   <= bit_q + 1'b1;
            state_q <= ST_CLEAR;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PXD_TRAIN_STATS_EN
  logic [4*(WIN_LOG+1)+$clog2(WIDTH)-1:0] stats_q;

  always_ff @(posedge mclk) begin
    if (mrst) begin
      stats_q <= '0;
    end else if (state_q == ST_DECIDE) begin
      stats_q <= {cnt3, cnt2, cnt1, cnt0, $clog2(WIDTH)'(bit_q)};
    end
  end

  assign train_stats = stats_q;
`endif

  assign pxd_in     = pxd_q;
  assign quad_cur   = quad_cur_q;
  assign train_err  = train_err_q;
  assign train_busy = busy_q;
  assign train_done = done_q;
  assign fsm_state  = state_q;

endmodule

// File: doc/pxd_quad_train.md
Name: pxd_quad_train

Overview:
- Parametrised successor to the single-line pixel data capture: selects one of four 90-degree sample phases per pixel bit for a WIDTH-bit sensor bus.
- Per-bit quadrant is set manually or by a built-in training FSM, which measures edge positions and picks the phase farthest from the data transitions.
- Sits in the mclk domain after the per-bit 4:1 deserialisers, ahead of the sensor channel pipeline.

Parameters:
- WIDTH, 12, number of pixel data bits.
- WIN_LOG, 10, training window per bit is 2^WIN_LOG mclk cycles.
- QUAD_INIT, 0, reset quadrant (2 bits) applied to every bit.

Ports:
- mclk  input  1  system clock; all logic @posedge mclk.
- mrst  input  1  reset, synchronous, active-high.
- dout_quads  input  4*WIDTH  deserialised samples; bit i phases 0..3 at [4i+3:4i], phase 0 earliest.
- pxd_in  output  WIDTH  selected pixel data, registered.
- quad_manual  input  2*WIDTH  manual quadrants, bit i at [2i+1:2i].
- quad_set  input  1  pulse: load quad_manual into all bits.
- train_start  input  1  pulse: start auto-training of all bits.
- train_busy  output  1  training in progress.
- train_done  output  1  one-cycle pulse at training end.
- train_err  output  WIDTH  bit i saw zero edges in its window.
- quad_cur  output  2*WIDTH  currently applied quadrants.

Behaviour:
- Reset: pxd_in=0, quad_cur=all QUAD_INIT, train_busy=0, train_done=0, train_err=0, FSM=IDLE, counters=0.
- Data path: pxd_in[i] <= dout_quads[4i+quad_cur[2i+1:2i]]; latency 1 cycle; a quadrant change takes effect on the following cycle.
- Edge boundaries per bit: b0=s0^s1, b1=s1^s2, b2=s2^s3, b3=s3(prev cycle)^s0. Register s3 per bit every cycle.
- FSM states:
  - IDLE: on train_start go CLEAR with bit index=0.
  - CLEAR: zero four edge counters (WIN_LOG+1 bits) and the window counter; go ACCUM.
  - ACCUM: each cycle add b0..b3 of the current bit to counters k=0..3; after exactly 2^WIN_LOG cycles go DECIDE. The first ACCUM cycle for bit 0 uses prev s3 as registered (no special case).
  - DECIDE: k = lowest index holding the maximum count. If max>0, quad_cur[bit] <= (k+2) mod 4 and train_err[bit] <= 0. If all counts are 0, quad_cur is unchanged and train_err[bit] <= 1. Go NEXT.
  - NEXT: if bit==WIDTH-1 go DONE, else increment bit and go CLEAR.
  - DONE: assert train_done for 1 cycle; go IDLE.
- train_busy=1 in all states except IDLE.
- Counters cannot overflow: the maximum is 2^WIN_LOG.
- quad_set while IDLE loads all quadrants next cycle. quad_set while busy is ignored. train_start while busy is ignored.
- quad_set and train_start in the same IDLE cycle: quad_set loads first, then training starts.
- train_err bits are held until overwritten by a later training or cleared by mrst. quad_set does not clear them.
- mrst mid-training: immediate return to reset state, no train_done pulse.

Optional Feature:
- Macro: PXD_TRAIN_STATS_EN.
- Defined: adds output train_stats [4*(WIN_LOG+1)+$clog2(WIDTH)-1:0]. It holds the four edge counts and bit index captured at each DECIDE, is held until the next DECIDE, and resets to 0.
- Undefined: no port, no capture registers; all other behaviour is identical.

Decomposition:
- Shared package holds the FSM state enum (IDLE, CLEAR, ACCUM, DECIDE, NEXT, DONE), phase/quadrant width constant (2), and a function returning the lowest index of the maximum of four counts.
- Natural sub-module pxd_edge_hist: the four counters plus window counter for one bit (clear, accumulate, window-end flag). Instantiate once, muxed over the bit index.

Test Plan:
- Reset, then dout_quads=all 1 with QUAD_INIT=2 -> pxd_in=all 1 one cycle after reset release; quad_cur=all 2'b10.
- quad_manual bit0=3, others 0; quad_set; drive bit0 phases 4'b1000 -> pxd_in[0]=1 two cycles after quad_set.
- WIDTH=2, WIN_LOG=4; bit0 toggles each cycle with edge between s1 and s2, bit1 edge at b3 -> after training quad_cur bit0=3, bit1=1; train_done pulses once at cycle 2*(2^4+3)+1 after start.
- Constant bit1 during training -> train_err[1]=1, quad_cur bit1 unchanged, train_err[0]=0.
- Equal counts on b1 and b3 -> k=1 chosen, quadrant=3.
- mrst asserted in ACCUM of bit1 -> next cycle train_busy=0, quad_cur=QUAD_INIT, no train_done.
- train_start repeated while busy -> ignored; only one train_done.
